tca9539_i2c_slave: RTL and testbench

- I2C target front-end for the TCA9539 GPIO-expander model.
- Oversamples scl/sda on the fast simulation clock and detects START, repeated START and STOP.
- Matches the 7-bit device address, captures the command byte and issues register write and read accesses to the downstream 8x8 register file.
- Drives SDA for ACK and read data through an open-drain enable; the top level ties sda_oe to the inout sda pin.

---
 rtl/tca9539_pkg.sv | 50 +++++
 rtl/i2c_bus_sync.sv | 59 +++++
 rtl/tca9539_i2c_slave.sv | 244 ++++++++++++++++++++++++
 tb/tb_tca9539_i2c_slave.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tca9539_pkg.sv
// ---------------------------------------------------------------------------
// tca9539_pkg
// Shared types for the TCA9539 GPIO-expander model:
//   - cmd_e      : the eight command-byte register indices
//   - state_e    : I2C target front-end FSM states
//   - ADDR_BASE_DEFAULT : upper five bits of the 7-bit device address
//   - pair_toggle / addr_match : small helpers used by the front-end
// ---------------------------------------------------------------------------
package tca9539_pkg;

    typedef enum logic [2:0] {
        CMD_IN0  = 3'd0,
        CMD_IN1  = 3'd1,
        CMD_OUT0 = 3'd2,
        CMD_OUT1 = 3'd3,
        CMD_POL0 = 3'd4,
        CMD_POL1 = 3'd5,
        CMD_CFG0 = 3'd6,
        CMD_CFG1 = 3'd7
    } cmd_e;

    localparam logic [4:0] ADDR_BASE_DEFAULT = 5'b11101;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_CMD      = 3'd3,
        ST_WR_DATA  = 3'd4,
        ST_RD_DATA  = 3'd5,
        ST_IGNORE   = 3'd6
    } state_e;

    // Auto-increment only flips bit 0, so the pointer stays inside its
    // register pair (0/1, 2/3, 4/5, 6/7).
    function automatic cmd_e pair_toggle(input cmd_e ptr);
        logic [2:0] v;
        v = ptr;
        return cmd_e'({v[2:1], ~v[0]});
    endfunction

    // Compare the first seven received bits against {base, a1, a0}.
    function automatic logic addr_match(input logic [6:0] rx_addr,
                                        input logic [4:0] base,
                                        input logic       pin_a1,
                                        input logic       pin_a0);
        return (rx_addr == {base, pin_a1, pin_a0});
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// ---------------------------------------------------------------------------
// i2c_bus_sync
// Synchronises SCL/SDA into the fast clock domain and produces single-clock
// event pulses on the synchronised signals.
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_scl, i_sda     : raw bus lines
//   o_sda            : synchronised SDA level (bit sampling)
//   o_scl_rise/fall  : SCL edge pulses
//   o_start/o_stop   : START (SDA falls, SCL high) / STOP (SDA rises, SCL high)
// ---------------------------------------------------------------------------
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_hist;
    logic                   r_sda_hist;
    logic                   w_scl;
    logic                   w_sda;

    assign w_scl = r_scl_sync[SYNC_STAGES-1];
    assign w_sda = r_sda_sync[SYNC_STAGES-1];

    // Synchroniser chains plus one history flop; idle bus level is high.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_scl_sync <= {SYNC_STAGES{1'b1}};
            r_sda_sync <= {SYNC_STAGES{1'b1}};
            r_scl_hist <= 1'b1;
            r_sda_hist <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_hist <= w_scl;
            r_sda_hist <= w_sda;
        end
    end

    assign o_sda      = w_sda;
    assign o_scl_rise = w_scl & ~r_scl_hist;
    assign o_scl_fall = ~w_scl & r_scl_hist;
    // SCL must be high in both samples so an SDA change that races a
    // clock edge is never mistaken for a bus condition.
    assign o_start    = w_scl & r_scl_hist & r_sda_hist & ~w_sda;
    assign o_stop     = w_scl & r_scl_hist & ~r_sda_hist & w_sda;

endmodule

// File: rtl/tca9539_i2c_slave.sv
// ---------------------------------------------------------------------------
// tca9539_i2c_slave
// I2C target front-end of the TCA9539 model: address match, command byte
// capture, register write/read accesses and open-drain SDA drive.
// Ports:
//   clk, reset_n        : clock (>= 8x SCL), asynchronous active-low reset
//   a1, a0              : address select pins (sampled at address match)
//   scl, sda_in         : bus lines
//   sda_oe              : 1 pulls SDA low
//   reg_wr_en/addr/data : one-clock register write strobe
//   reg_rd_addr         : register currently selected for read
//   reg_rd_data         : combinational read data for reg_rd_addr
//   reg_rd_strobe       : one-clock pulse when a read byte is fetched
//   busy                : matched transaction in progress
// ---------------------------------------------------------------------------
module tca9539_i2c_slave
    import tca9539_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [4:0] ADDR_BASE   = ADDR_BASE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       a1,
    input  logic       a0,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       reg_wr_en,
    output logic [2:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic [2:0] reg_rd_addr,
    input  logic [7:0] reg_rd_data,
    output logic       reg_rd_strobe,
    output logic       busy
);

    logic w_sda;
    logic w_rise;
    logic w_fall;
    logic w_start;
    logic w_stop;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_sync (
        .i_clk      (clk),
        .i_reset_n  (reset_n),
        .i_scl      (scl),
        .i_sda      (sda_in),
        .o_sda      (w_sda),
        .o_scl_rise (w_rise),
        .o_scl_fall (w_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    state_e     r_state,     w_state_nxt;
    logic [3:0] r_cnt,       w_cnt_nxt;
    logic [7:0] r_shift,     w_shift_nxt;
    cmd_e       r_ptr,       w_ptr_nxt;
    logic       r_rw,        w_rw_nxt;
    logic       r_oe,        w_oe_nxt;
    logic       r_busy,      w_busy_nxt;
    logic       r_wr_en,     w_wr_en_nxt;
    logic [2:0] r_wr_addr,   w_wr_addr_nxt;
    logic [7:0] r_wr_data,   w_wr_data_nxt;
    logic       r_rd_strobe, w_rd_strobe_nxt;
    logic [7:0] w_byte;

    // Byte as it stands once the bit on the current SCL rise is shifted in.
    assign w_byte = {r_shift[6:0], w_sda};

    // Next-state and datapath decode; r_cnt counts received bits 0..8, the
    // rise after count 8 is the ACK clock and wraps the count to 0.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_shift_nxt     = r_shift;
        w_ptr_nxt       = r_ptr;
        w_rw_nxt        = r_rw;
        w_oe_nxt        = r_oe;
        w_busy_nxt      = r_busy;
        w_wr_en_nxt     = 1'b0;
        w_wr_addr_nxt   = r_wr_addr;
        w_wr_data_nxt   = r_wr_data;
        w_rd_strobe_nxt = 1'b0;

        // The strobe cycle is when reg_rd_addr already shows the new pointer,
        // so the read byte is captured one clock after the strobe is raised.
        if (r_rd_strobe) begin
            w_shift_nxt = reg_rd_data;
        end else begin
            w_shift_nxt = r_shift;
        end

        if (w_stop) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 4'd0;
            w_oe_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
        end else if (w_start) begin
            w_state_nxt = ST_ADDR;
            w_cnt_nxt   = 4'd0;
            w_oe_nxt    = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_oe_nxt = 1'b0;
                end
                ST_ADDR: begin
                    if (w_rise) begin
                        w_shift_nxt = w_byte;
                        w_cnt_nxt   = r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            if (addr_match(w_byte[7:1], ADDR_BASE, a1, a0)) begin
                                w_state_nxt = ST_ADDR_ACK;
                                w_rw_nxt    = w_byte[0];
                                w_busy_nxt  = 1'b1;
                            end else begin
                                w_state_nxt = ST_IGNORE;
                                w_busy_nxt  = 1'b0;
                            end
                        end else begin
                            w_state_nxt = ST_ADDR;
                        end
                    end else begin
                        w_oe_nxt = 1'b0;
                    end
                end
                ST_ADDR_ACK: begin
                    if (w_fall) begin
                        w_oe_nxt = 1'b1;
                    end else if (w_rise) begin
                        w_cnt_nxt = 4'd0;
                        if (r_rw) begin
                            w_state_nxt     = ST_RD_DATA;
                            w_rd_strobe_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_CMD;
                        end
                    end else begin
                        w_state_nxt = ST_ADDR_ACK;
                    end
                end
                ST_CMD, ST_WR_DATA: begin
                    if (w_fall) begin
                        // ACK is held from the fall after bit 8 to the fall after the ACK clock.
                        w_oe_nxt = (r_cnt == 4'd8);
                    end else if (w_rise && (r_cnt < 4'd8)) begin
                        w_shift_nxt = w_byte;
                        w_cnt_nxt   = r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            if (r_state == ST_CMD) begin
                                w_ptr_nxt = cmd_e'(w_byte[2:0]);
                            end else begin
                                w_wr_en_nxt   = 1'b1;
                                w_wr_addr_nxt = r_ptr;
                                w_wr_data_nxt = w_byte;
                            end
                        end else begin
                            w_ptr_nxt = r_ptr;
                        end
                    end else if (w_rise) begin
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = ST_WR_DATA;
                        if (r_state == ST_WR_DATA) begin
                            w_ptr_nxt = pair_toggle(r_ptr);
                        end else begin
                            w_ptr_nxt = r_ptr;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                end
                ST_RD_DATA: begin
                    if (w_fall) begin
                        // Open drain: a 0 data bit pulls low, a 1 releases.
                        w_oe_nxt = (r_cnt < 4'd8) ? ~r_shift[7] : 1'b0;
                    end else if (w_rise && (r_cnt < 4'd8)) begin
                        w_shift_nxt = {r_shift[6:0], 1'b0};
                        w_cnt_nxt   = r_cnt + 4'd1;
                    end else if (w_rise) begin
                        w_cnt_nxt = 4'd0;
                        if (!w_sda) begin
                            w_ptr_nxt       = pair_toggle(r_ptr);
                            w_rd_strobe_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_IGNORE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                end
                ST_IGNORE: begin
                    w_oe_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_oe_nxt    = 1'b0;
                    w_busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers; reset releases SDA asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_shift     <= 8'd0;
            r_ptr       <= CMD_IN0;
            r_rw        <= 1'b0;
            r_oe        <= 1'b0;
            r_busy      <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= 3'd0;
            r_wr_data   <= 8'd0;
            r_rd_strobe <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_ptr       <= w_ptr_nxt;
            r_rw        <= w_rw_nxt;
            r_oe        <= w_oe_nxt;
            r_busy      <= w_busy_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_rd_strobe <= w_rd_strobe_nxt;
        end
    end

    assign sda_oe        = r_oe;
    assign reg_wr_en     = r_wr_en;
    assign reg_wr_addr   = r_wr_addr;
    assign reg_wr_data   = r_wr_data;
    assign reg_rd_addr   = r_ptr;
    assign reg_rd_strobe = r_rd_strobe;
    assign busy          = r_busy;

endmodule

// File: tb/tb_tca9539_i2c_slave.sv
// ---------------------------------------------------------------------------
// tb_tca9539_i2c_slave
// Directed bench: a bus-master model issues transactions and pushes the
// expected register strobes, ACK bits and read bytes into queues; a single
// monitor process pops and compares whenever the DUT strobes or the master
// reports an observed bus value.
// ---------------------------------------------------------------------------
module tb_tca9539_i2c_slave;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       a1 = 1'b0;
    logic       a0 = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       bus_sda;
    logic       sda_oe;
    logic       reg_wr_en;
    logic [2:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic [2:0] reg_rd_addr;
    logic [7:0] reg_rd_data;
    logic       reg_rd_strobe;
    logic       busy;
    logic [7:0] rd_mem [0:7];

    int checks = 0;
    int failures = 0;

    logic [10:0] exp_wr_q [$];
    logic [2:0]  exp_rd_q [$];
    logic [7:0]  exp_obs_q [$];
    string       obs_name_q [$];
    logic        obs_valid = 1'b0;
    logic [7:0]  obs_val = 8'd0;

    logic [10:0] mon_wr;
    logic [2:0]  mon_rd;
    logic [7:0]  mon_obs;
    string       mon_name;

    assign bus_sda     = sda_m & ~sda_oe;
    assign reg_rd_data = rd_mem[reg_rd_addr];

    always #5 clk = ~clk;

    tca9539_i2c_slave dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .a1            (a1),
        .a0            (a0),
        .scl           (scl_m),
        .sda_in        (bus_sda),
        .sda_oe        (sda_oe),
        .reg_wr_en     (reg_wr_en),
        .reg_wr_addr   (reg_wr_addr),
        .reg_wr_data   (reg_wr_data),
        .reg_rd_addr   (reg_rd_addr),
        .reg_rd_data   (reg_rd_data),
        .reg_rd_strobe (reg_rd_strobe),
        .busy          (busy)
    );

    // Monitor: all comparisons happen here.
    always @(negedge clk) begin
        if (reg_wr_en) begin
            checks++;
            if (exp_wr_q.size() == 0) begin
                failures++;
                $display("FAIL wr_strobe: got addr=%0d data=%02h, want no write", reg_wr_addr, reg_wr_data);
            end else begin
                mon_wr = exp_wr_q.pop_front();
                if ({reg_wr_addr, reg_wr_data} !== mon_wr) begin
                    failures++;
                    $display("FAIL wr_strobe: got addr=%0d data=%02h, want addr=%0d data=%02h",
                             reg_wr_addr, reg_wr_data, mon_wr[10:8], mon_wr[7:0]);
                end
            end
        end
        if (reg_rd_strobe) begin
            checks++;
            if (exp_rd_q.size() == 0) begin
                failures++;
                $display("FAIL rd_strobe: got addr=%0d, want no read strobe", reg_rd_addr);
            end else begin
                mon_rd = exp_rd_q.pop_front();
                if (reg_rd_addr !== mon_rd) begin
                    failures++;
                    $display("FAIL rd_strobe: got addr=%0d, want addr=%0d", reg_rd_addr, mon_rd);
                end
            end
        end
        if (obs_valid) begin
            checks++;
            if (exp_obs_q.size() == 0) begin
                failures++;
                $display("FAIL obs: got %02h with no expectation queued", obs_val);
            end else begin
                mon_obs  = exp_obs_q.pop_front();
                mon_name = obs_name_q.pop_front();
                if (obs_val !== mon_obs) begin
                    failures++;
                    $display("FAIL %s: got %02h, want %02h", mon_name, obs_val, mon_obs);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, want end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic report_obs(input logic [7:0] v);
        @(posedge clk);
        obs_val   = v;
        obs_valid = 1'b1;
        @(posedge clk);
        obs_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        exp_obs_q.push_back(exp);
        obs_name_q.push_back(name);
        report_obs(act);
    endtask

    // One SCL period: data set mid-low, sampled mid-high; exits with SCL low.
    task automatic clk_bit(input logic drive, output logic seen);
        repeat (3) @(negedge clk);
        sda_m = drive;
        repeat (7) @(negedge clk);
        scl_m = 1'b1;
        repeat (5) @(negedge clk);
        seen = bus_sda;
        repeat (5) @(negedge clk);
        scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        repeat (5) @(negedge clk);
        sda_m = 1'b1;
        repeat (5) @(negedge clk);
        scl_m = 1'b1;
        repeat (5) @(negedge clk);
        sda_m = 1'b0;
        repeat (5) @(negedge clk);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        repeat (5) @(negedge clk);
        sda_m = 1'b0;
        repeat (5) @(negedge clk);
        scl_m = 1'b1;
        repeat (5) @(negedge clk);
        sda_m = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic wr_byte(input string name, input logic [7:0] b, input logic exp_ack);
        logic seen;
        exp_obs_q.push_back({7'd0, exp_ack});
        obs_name_q.push_back(name);
        for (int i = 7; i >= 0; i--) clk_bit(b[i], seen);
        clk_bit(1'b1, seen);
        report_obs({7'd0, seen});
    endtask

    task automatic rd_byte(input string name, input logic mack, input logic [7:0] exp);
        logic       seen;
        logic [7:0] v;
        exp_obs_q.push_back(exp);
        obs_name_q.push_back(name);
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, seen);
            v[i] = seen;
        end
        clk_bit(mack, seen);
        report_obs(v);
    endtask

    initial begin
        logic       seen;
        logic       oe_before;
        logic       oe_after;
        logic [7:0] b;

        for (int i = 0; i < 8; i++) rd_mem[i] = 8'h00;
        rd_mem[0] = 8'h12;
        rd_mem[1] = 8'h34;

        // Reset values
        repeat (4) @(negedge clk);
        chk("rst_sda_oe", {7'd0, sda_oe}, 8'd0);
        chk("rst_wr_en", {7'd0, reg_wr_en}, 8'd0);
        chk("rst_wr_addr", {5'd0, reg_wr_addr}, 8'd0);
        chk("rst_wr_data", reg_wr_data, 8'd0);
        chk("rst_rd_strobe", {7'd0, reg_rd_strobe}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_rd_addr", {5'd0, reg_rd_addr}, 8'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single write to CFG0
        exp_wr_q.push_back({3'd6, 8'hF0});
        i2c_start();
        wr_byte("t1_addr_ack", 8'hE8, 1'b0);
        chk("t1_busy", {7'd0, busy}, 8'd1);
        wr_byte("t1_cmd_ack", 8'h06, 1'b0);
        wr_byte("t1_data_ack", 8'hF0, 1'b0);
        i2c_stop();
        chk("t1_busy_after_stop", {7'd0, busy}, 8'd0);

        // Burst write toggles within the OUT pair
        exp_wr_q.push_back({3'd2, 8'hAA});
        exp_wr_q.push_back({3'd3, 8'h55});
        exp_wr_q.push_back({3'd2, 8'h11});
        i2c_start();
        wr_byte("t2_addr_ack", 8'hE8, 1'b0);
        wr_byte("t2_cmd_ack", 8'h02, 1'b0);
        wr_byte("t2_d0_ack", 8'hAA, 1'b0);
        wr_byte("t2_d1_ack", 8'h55, 1'b0);
        wr_byte("t2_d2_ack", 8'h11, 1'b0);
        i2c_stop();

        // Set pointer, repeated START, read two bytes (ACK then NACK)
        exp_rd_q.push_back(3'd0);
        exp_rd_q.push_back(3'd1);
        i2c_start();
        wr_byte("t3_addr_ack", 8'hE8, 1'b0);
        wr_byte("t3_cmd_ack", 8'h00, 1'b0);
        i2c_start();
        wr_byte("t3_raddr_ack", 8'hE9, 1'b0);
        rd_byte("t3_rd0", 1'b0, 8'h12);
        rd_byte("t3_rd1", 1'b1, 8'h34);
        chk("t3_sda_released", {7'd0, sda_oe}, 8'd0);
        i2c_stop();

        // Address pins select 0x76: 0x74 ignored, 0x76 acknowledged
        a1 = 1'b1;
        a0 = 1'b0;
        i2c_start();
        wr_byte("t4_wrong_addr_nack", 8'hE8, 1'b1);
        chk("t4_busy_idle", {7'd0, busy}, 8'd0);
        chk("t4_sda_oe", {7'd0, sda_oe}, 8'd0);
        i2c_start();
        wr_byte("t4_ec_ack", 8'hEC, 1'b0);
        chk("t4_busy", {7'd0, busy}, 8'd1);
        i2c_stop();
        a1 = 1'b0;

        // STOP after four data bits: no write
        i2c_start();
        wr_byte("t5_addr_ack", 8'hE8, 1'b0);
        wr_byte("t5_cmd_ack", 8'h04, 1'b0);
        b = 8'hA5;
        for (int i = 7; i >= 4; i--) clk_bit(b[i], seen);
        i2c_stop();
        chk("t5_busy", {7'd0, busy}, 8'd0);
        chk("t5_sda_oe", {7'd0, sda_oe}, 8'd0);

        // START mid-byte aborts it; following write lands
        exp_wr_q.push_back({3'd3, 8'h99});
        i2c_start();
        wr_byte("t5b_addr_ack", 8'hE8, 1'b0);
        wr_byte("t5b_cmd_ack", 8'h03, 1'b0);
        for (int i = 0; i < 3; i++) clk_bit(1'b1, seen);
        i2c_start();
        wr_byte("t5b_addr2_ack", 8'hE8, 1'b0);
        wr_byte("t5b_cmd2_ack", 8'h03, 1'b0);
        wr_byte("t5b_data_ack", 8'h99, 1'b0);
        i2c_stop();

        // Reset while the address ACK is driven
        i2c_start();
        b = 8'hE8;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], seen);
        for (int i = 0; i < 20 && !sda_oe; i++) @(negedge clk);
        oe_before = sda_oe;
        reset_n = 1'b0;
        #1;
        oe_after = sda_oe;
        chk("t6_ack_driven", {7'd0, oe_before}, 8'd1);
        chk("t6_async_release", {7'd0, oe_after}, 8'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk("t6_ptr_reset", {5'd0, reg_rd_addr}, 8'd0);
        exp_wr_q.push_back({3'd7, 8'h0F});
        i2c_start();
        wr_byte("t6_addr_ack", 8'hE8, 1'b0);
        wr_byte("t6_cmd_ack", 8'h07, 1'b0);
        wr_byte("t6_data_ack", 8'h0F, 1'b0);
        i2c_stop();

        repeat (10) @(negedge clk);
        chk("wr_q_left", 8'(exp_wr_q.size()), 8'd0);
        chk("rd_q_left", 8'(exp_rd_q.size()), 8'd0);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
